// File: rtl/moore_steer_tx.sv
// Transmit-side driver for the 4-state serial Moore recognizer: steers it to a
// target state or serializes a literal pattern, while tracking its state locally.
module moore_steer_tx #(
    parameter int MAX_BITS = 8,
    parameter int LEN_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_mode,
    input  logic [1:0]          req_target,
    input  logic [MAX_BITS-1:0] req_bits,
    input  logic [LEN_W-1:0]    req_len,
    output logic                x_out,
    output logic                done,
    output logic                busy,
    output logic [1:0]          shadow_state,
    output logic                y_model
);

    typedef enum logic [1:0] {
        IDLE,
        STEER,
        RAW
    } fsm_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    fsm_t                fsm;
    logic [1:0]          target;
    logic [MAX_BITS-1:0] bits;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    index;

    logic                at_target;
    logic                raw_end;
    logic                hop_bit;
    logic                raw_bit;

    // Transition function of the downstream recognizer.
    function automatic logic [1:0] shadow_next(input logic [1:0] s, input logic x);
        logic [1:0] n;
        case (s)
            2'd0:    n = x ? 2'd2 : 2'd1;
            2'd1:    n = x ? 2'd2 : 2'd0;
            2'd2:    n = x ? 2'd3 : 2'd2;
            default: n = x ? 2'd1 : 2'd3;
        endcase
        return n;
    endfunction

    // x_out and done depend only on registered state, so a request can never
    // reach the serial line in the cycle it is presented.
    always_comb begin
        at_target = (shadow_state == target);
        raw_end   = (index == len);
        hop_bit   = !(((target == 2'd0) && (shadow_state == 2'd1)) ||
                      ((target == 2'd1) && (shadow_state == 2'd0)));
        raw_bit   = 1'b0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (index == LEN_W'(i)) begin
                raw_bit = bits[i];
            end
        end
        x_out = 1'b0;
        done  = 1'b0;
        case (fsm)
            STEER: begin
                if (at_target) done = 1'b1;
                else           x_out = hop_bit;
            end
            RAW: begin
                if (raw_end) done = 1'b1;
                else         x_out = raw_bit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm          <= IDLE;
            shadow_state <= 2'd0;
            target       <= 2'd0;
            bits         <= '0;
            len          <= '0;
            index        <= '0;
        end else begin
            // The recognizer consumes x_out on every edge, idle cycles included.
            shadow_state <= shadow_next(shadow_state, x_out);
            case (fsm)
                IDLE: begin
                    if (req_valid) begin
                        index <= '0;
                        if (req_mode) begin
                            bits <= req_bits;
                            len  <= (req_len > MAX_LEN) ? MAX_LEN : req_len;
                            fsm  <= RAW;
                        end else begin
                            target <= req_target;
                            fsm    <= STEER;
                        end
                    end
                end
                STEER: begin
                    if (at_target) fsm <= IDLE;
                end
                RAW: begin
                    if (raw_end) fsm   <= IDLE;
                    else         index <= index + LEN_W'(1);
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign busy      = (fsm == STEER) || (fsm == RAW);
    assign req_ready = (fsm == IDLE);
    assign y_model   = (shadow_state == 2'd1) || (shadow_state == 2'd2);

endmodule

// File: tb/tb_moore_steer_tx.sv
// Scoreboard bench for moore_steer_tx: requests push expected per-cycle
// x/done items; a negedge monitor pops them and tracks the recognizer state.
module tb_moore_steer_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_mode;
    logic [1:0] req_target;
    logic [7:0] req_bits;
    logic [3:0] req_len;
    logic       x_out;
    logic       done;
    logic       busy;
    logic [1:0] shadow_state;
    logic       y_model;

    typedef struct packed {
        logic x;
        logic d;
    } item_t;

    item_t      exp_q[$];
    logic [1:0] model_shadow;
    logic       cyc_idle;
    int         checks   = 0;
    int         failures = 0;

    moore_steer_tx #(.MAX_BITS(8), .LEN_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_target   (req_target),
        .req_bits     (req_bits),
        .req_len      (req_len),
        .x_out        (x_out),
        .done         (done),
        .busy         (busy),
        .shadow_state (shadow_state),
        .y_model      (y_model)
    );

    always #5 clk = ~clk;

    // Recognizer transition table written directly from the state diagram.
    function automatic logic [1:0] shadowStep(input logic [1:0] s, input logic x);
        logic [1:0] on0 [4];
        logic [1:0] on1 [4];
        on0 = '{2'd1, 2'd0, 2'd2, 2'd3};
        on1 = '{2'd2, 2'd2, 2'd3, 2'd1};
        return x ? on1[s] : on0[s];
    endfunction

    // Shortest bit sequence (sent LSB first) from one state to another, by search.
    function automatic void steerPath(input logic [1:0] from, input logic [1:0] to,
                                      output int n, output logic [2:0] seq);
        logic [1:0] st;
        n   = -1;
        seq = 3'd0;
        for (int l = 0; l <= 3; l++) begin
            for (int s = 0; s < (1 << l); s++) begin
                if (n < 0) begin
                    st = from;
                    for (int k = 0; k < l; k++) st = shadowStep(st, s[k]);
                    if (st == to) begin
                        n   = l;
                        seq = s[2:0];
                    end
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: each cycle either pops the next expected item or expects idle.
    always @(negedge clk) begin
        item_t it;
        logic  ex;
        logic  ed;
        if (!rst_n) begin
            cyc_idle = 1'b0;
        end else begin
            cyc_idle = (exp_q.size() == 0);
            ex = 1'b0;
            ed = 1'b0;
            if (!cyc_idle) begin
                it = exp_q.pop_front();
                ex = it.x;
                ed = it.d;
            end
            checkOutput("busy", busy, !cyc_idle);
            checkOutput("req_ready", req_ready, cyc_idle);
            checkOutput("x_out", x_out, ex);
            checkOutput("done", done, ed);
            checkOutput("shadow_state", shadow_state, model_shadow);
            checkOutput("y_model", y_model, (model_shadow == 2'd1) || (model_shadow == 2'd2));
            model_shadow = shadowStep(model_shadow, ex);
        end
    end

    task automatic waitIdle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (cyc_idle) return;
        end
        checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input logic mode, input logic [1:0] tgt,
                                 input logic [7:0] pat, input logic [3:0] len);
        int         n;
        logic [2:0] seq;
        item_t      it;
        waitIdle();
        req_mode   = mode;
        req_target = tgt;
        req_bits   = pat;
        req_len    = len;
        req_valid  = 1'b1;
        // model_shadow already holds the state after this accept edge.
        if (mode) begin
            n = (len > 8) ? 8 : int'(len);
            for (int i = 0; i < n; i++) begin
                it.x = pat[i];
                it.d = 1'b0;
                exp_q.push_back(it);
            end
        end else begin
            steerPath(model_shadow, tgt, n, seq);
            for (int i = 0; i < n; i++) begin
                it.x = seq[i];
                it.d = 1'b0;
                exp_q.push_back(it);
            end
        end
        it.x = 1'b0;
        it.d = 1'b1;
        exp_q.push_back(it);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic busyPoke();
        @(negedge clk);
        #1;
        if (!cyc_idle) begin
            req_mode   = 1'($urandom);
            req_target = 2'($urandom);
            req_bits   = 8'($urandom);
            req_len    = 4'($urandom);
            req_valid  = 1'b1;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_shadow", shadow_state, 0);
        checkOutput("rst_x_out", x_out, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_y_model", y_model, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_mode   = 1'b0;
        req_target = 2'd0;
        req_bits   = 8'd0;
        req_len    = 4'd0;
        cyc_idle   = 1'b0;
        model_shadow = 2'd0;
        repeat (2) @(negedge clk);
        #2;
        checkReset();
        model_shadow = 2'd1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        applyStimulus(1'b0, 2'd3, 8'd0, 4'd0);
        applyStimulus(1'b1, 2'd0, 8'b0000_0001, 4'd1);
        applyStimulus(1'b0, 2'd0, 8'd0, 4'd0);
        applyStimulus(1'b0, 2'd0, 8'd0, 4'd0);
        applyStimulus(1'b1, 2'd0, 8'b0000_1011, 4'd4);
        applyStimulus(1'b1, 2'd0, 8'hA5, 4'd0);
        applyStimulus(1'b1, 2'd0, 8'h6D, 4'd12);
        busyPoke();
        busyPoke();
        applyStimulus(1'b0, 2'd2, 8'd0, 4'd0);
        busyPoke();

        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) busyPoke();
        end

        // Abort a RAW transfer with an asynchronous reset part-way through.
        applyStimulus(1'b1, 2'd0, 8'hFF, 4'd8);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset();
        exp_q.delete();
        @(negedge clk);
        #2;
        model_shadow = 2'd1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        applyStimulus(1'b0, 2'd3, 8'd0, 4'd0);
        waitIdle();
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
